// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready       operand handshake (A, B, signed_mode qualified by in_valid)
//   A, B                     N-bit multiplicand / multiplier
//   signed_mode              1 = operands are two's complement
//   out_valid, out_ready     result handshake
//   Product                  2N-bit result, qualified by out_valid
//   busy                     multiplier is computing or holding a result
interface seq_multiplier_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] Product;
  logic           busy;

  // Producer/consumer side that feeds operands and takes results.
  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, Product, busy
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, Product, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// N x N shift-add multiplier, one partial product per clock, unsigned or signed per transaction.
// Latency: out_valid rises N edges after the accepting edge; initiation interval N+2 cycles.
// Backpressure: result held in DONE until out_ready; no operands accepted outside IDLE.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (0 = reset)
//   bus    seq_multiplier_if.slave: in_valid/in_ready/A/B/signed_mode in,
//          out_valid/out_ready/Product out, busy high in CALC or DONE
module seq_multiplier #(
  parameter int N              = 8,
  parameter int SIGNED_SUPPORT = 1
) (
  input logic            clk,
  input logic            reset,
  seq_multiplier_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] partial;
  logic [2*N-1:0] acc_sum;
  logic [2*N-1:0] product;
  logic [CW-1:0]  cnt;

  logic           signed_active;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic           last_step;

  // With SIGNED_SUPPORT=0 this folds to 0 and all sign handling disappears.
  assign signed_active = bus.signed_mode && (SIGNED_SUPPORT != 0);

  // Magnitudes as unsigned N-bit values: |-2^(N-1)| = 2^(N-1) still fits.
  assign abs_a = (signed_active && bus.A[N-1]) ? (~bus.A + 1'b1) : bus.A;
  assign abs_b = (signed_active && bus.B[N-1]) ? (~bus.B + 1'b1) : bus.B;

  assign last_step = (state == CALC) && (cnt == CNT_LAST);

  // Partial product for bit cnt of the multiplier, aligned into the 2N-bit accumulator.
  always_comb begin
    partial = '0;
    if (mag_b[cnt]) begin
      partial = {{N{1'b0}}, mag_a} << cnt;
    end
    acc_sum = acc + partial;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = CALC;
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, accumulation and result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= signed_active && (bus.A[N-1] ^ bus.B[N-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          cnt <= cnt + CNT_ONE;
          if (last_step) begin
            // Negating zero yields zero, so a zero operand needs no special case.
            product <= neg ? (~acc_sum + 1'b1) : acc_sum;
          end
        end
        default: begin
          // DONE: everything holds; Product stays put until the next result loads.
        end
      endcase
    end
  end

  assign bus.Product = product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at N=8 (signed), N=4 (unsigned only) and N=16.
// Latency: n/a.
// Backpressure: out_ready driven per test; expected results queued at issue, popped by monitors.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_multiplier_if #(.N(8))  b8 ();
  seq_multiplier_if #(.N(4))  b4 ();
  seq_multiplier_if #(.N(16)) b16 ();

  seq_multiplier #(.N(8),  .SIGNED_SUPPORT(1)) dut8  (.clk(clk), .reset(reset), .bus(b8.slave));
  seq_multiplier #(.N(4),  .SIGNED_SUPPORT(0)) dut4  (.clk(clk), .reset(reset), .bus(b4.slave));
  seq_multiplier #(.N(16), .SIGNED_SUPPORT(1)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));

  int errors = 0;
  int checks = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];
  logic [31:0] q16[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint sa;
    longint sb;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  // Monitors: a result handshake happens at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (b8.out_valid === 1'b1 && b8.out_ready === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL p8_unexpected: got product %0h, expected no result", b8.Product);
      end else begin
        chk("p8_product", 64'(b8.Product), 64'(q8.pop_front()));
      end
    end
    if (b4.out_valid === 1'b1 && b4.out_ready === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL p4_unexpected: got product %0h, expected no result", b4.Product);
      end else begin
        chk("p4_product", 64'(b4.Product), 64'(q4.pop_front()));
      end
    end
    if (b16.out_valid === 1'b1 && b16.out_ready === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL p16_unexpected: got product %0h, expected no result", b16.Product);
      end else begin
        chk("p16_product", 64'(b16.Product), 64'(q16.pop_front()));
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input bit push);
    int n = 0;
    while (b8.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (b8.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send8_timeout: in_ready=%b, expected 1", b8.in_ready);
    end
    b8.in_valid = 1'b1; b8.A = a; b8.B = b; b8.signed_mode = sm;
    if (push) q8.push_back(exp);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic sm, input logic [7:0] exp);
    int n = 0;
    while (b4.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (b4.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send4_timeout: in_ready=%b, expected 1", b4.in_ready);
    end
    b4.in_valid = 1'b1; b4.A = a; b4.B = b; b4.signed_mode = sm;
    q4.push_back(exp);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic [31:0] exp);
    int n = 0;
    while (b16.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (b16.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send16_timeout: in_ready=%b, expected 1", b16.in_ready);
    end
    b16.in_valid = 1'b1; b16.A = a; b16.B = b; b16.signed_mode = sm;
    q16.push_back(exp);
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q4.size() != 0 || q16.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (q8.size() != 0 || q4.size() != 0 || q16.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: outstanding %0d/%0d/%0d, expected 0/0/0",
               q8.size(), q4.size(), q16.size());
      q8.delete(); q4.delete(); q16.delete();
    end
  endtask

  // Vectors for N=8: {A, B, signed_mode, expected}.
  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec8_t;

  vec8_t v8[7] = '{
    '{8'hFD, 8'h05, 1'b1, 16'hFFF1},   // -3 * 5 = -15
    '{8'h80, 8'h80, 1'b1, 16'h4000},   // -128 * -128
    '{8'h80, 8'h80, 1'b0, 16'h4000},   // 128 * 128
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},   // 255 * 255
    '{8'hFF, 8'hFF, 1'b1, 16'h0001},   // -1 * -1
    '{8'h00, 8'h85, 1'b1, 16'h0000},   // zero with negative partner
    '{8'h7F, 8'h80, 1'b1, 16'hC080}    // 127 * -128 = -16256
  };

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    reset = 1'b0;
    b8.in_valid  = 1'b0; b8.A  = '0; b8.B  = '0; b8.signed_mode  = 1'b0; b8.out_ready  = 1'b1;
    b4.in_valid  = 1'b0; b4.A  = '0; b4.B  = '0; b4.signed_mode  = 1'b0; b4.out_ready  = 1'b1;
    b16.in_valid = 1'b0; b16.A = '0; b16.B = '0; b16.signed_mode = 1'b0; b16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(b8.in_ready),  64'd1);
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_busy",      64'(b8.busy),      64'd0);
    chk("rst_product",   64'(b8.Product),   64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: unsigned 13*11, latency and busy.
    b8.out_ready = 1'b0;
    send8(8'd13, 8'd11, 1'b0, 16'd143, 1'b1);
    chk("t1_busy_calc", 64'(b8.busy), 64'd1);
    chk("t1_in_ready_calc", 64'(b8.in_ready), 64'd0);
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("t1_latency", 64'(lat), 64'd8);
    chk("t1_busy_done", 64'(b8.busy), 64'd1);
    chk("t1_product", 64'(b8.Product), 64'd143);
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_out_valid_after", 64'(b8.out_valid), 64'd0);
    chk("t1_in_ready_after",  64'(b8.in_ready),  64'd1);
    chk("t1_busy_after",      64'(b8.busy),      64'd0);

    // 2: signed / unsigned vector table.
    foreach (v8[i]) send8(v8[i].a, v8[i].b, v8[i].sm, v8[i].exp, 1'b1);
    drain();

    // 3: backpressure with new operands offered during DONE.
    b8.out_ready = 1'b0;
    send8(8'd20, 8'd3, 1'b0, 16'd60, 1'b1);
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    for (int k = 0; k < 5; k++) begin
      b8.in_valid = 1'b1; b8.A = 8'd1; b8.B = 8'd1; b8.signed_mode = 1'b0;
      @(posedge clk); #1;
      chk("t3_out_valid_held", 64'(b8.out_valid), 64'd1);
      chk("t3_product_held",   64'(b8.Product),   64'd60);
      chk("t3_in_ready_low",   64'(b8.in_ready),  64'd0);
    end
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_out_valid_drop", 64'(b8.out_valid), 64'd0);
    chk("t3_in_ready_back",  64'(b8.in_ready),  64'd1);
    @(posedge clk); #1;
    chk("t3_no_accept", 64'(b8.busy), 64'd0);

    // 4: reset during CALC step 3 aborts the transaction.
    send8(8'd200, 8'd100, 1'b0, 16'd0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t4_busy_before", 64'(b8.busy), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t4_product",   64'(b8.Product),   64'd0);
    chk("t4_out_valid", 64'(b8.out_valid), 64'd0);
    chk("t4_in_ready",  64'(b8.in_ready),  64'd1);
    chk("t4_busy",      64'(b8.busy),      64'd0);
    reset = 1'b1;
    send8(8'd7, 8'd6, 1'b0, 16'd42, 1'b1);
    drain();
    repeat (20) @(posedge clk);
    #1;

    // 5: operands and in_valid wiggle while CALC runs.
    send8(8'd9, 8'd9, 1'b0, 16'd81, 1'b1);
    for (int k = 0; k < 5; k++) begin
      b8.in_valid = 1'b1;
      b8.A = 8'($urandom); b8.B = 8'($urandom); b8.signed_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b8.A = 8'($urandom); b8.B = 8'($urandom);
      @(posedge clk); #1;
    end
    drain();

    // 6a: N=4 without signed support.
    b4.out_ready = 1'b0;
    send4(4'hF, 4'hF, 1'b1, 8'hE1);
    lat = 0;
    while (b4.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("t6_latency4", 64'(lat), 64'd4);
    b4.out_ready = 1'b1;
    send4(4'h8, 4'h8, 1'b1, 8'h40);
    send4(4'hF, 4'h1, 1'b1, 8'h0F);
    drain();

    // 6b: N=16 corners, then random against the reference.
    send16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    send16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    send16(16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF);
    send16(16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000);
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      send16(ra, rb, rs, ref16(ra, rb, rs));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
